// File: rtl/ir_fetch_seq.sv
// ----------------------------------------------------------------------------
// ir_fetch_seq
// Two-byte instruction fetch sequencer placed downstream of the address
// register file (ARF). It puts PC on the ARF B port and uses it as the memory
// address. It reads the low and then the high instruction byte through a ready
// handshake, and pulses the ARF increment after each byte. It then presents
// the assembled 16-bit instruction register.
//
// Parameters
//   TIMEOUT        consecutive not-ready cycles in a request state before the
//                  fetch aborts (1..255)
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   start          request one fetch (sampled only in IDLE)
//   pc_addr        ARF out_b (PC while arf_out_b_sel = 2'b11)
//   mem_data       memory read data, valid with mem_rdy
//   mem_rdy        memory read complete
//   mem_rd         memory read request
//   mem_addr       memory address (pc_addr while mem_rd, else 0)
//   arf_out_b_sel  ARF out_b_sel
//   arf_funsel     ARF funsel (2'b01 = increment)
//   arf_r_sel      ARF r_sel (bit 0 = PC enable)
//   ir             assembled instruction {second byte, first byte}
//   ir_valid       one-cycle pulse, ir updated this cycle
//   busy           high in every state except IDLE
//   fetch_err      one-cycle pulse, fetch aborted on timeout
// ----------------------------------------------------------------------------
module ir_fetch_seq #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  pc_addr,
    input  logic [7:0]  mem_data,
    input  logic        mem_rdy,
    output logic        mem_rd,
    output logic [7:0]  mem_addr,
    output logic [1:0]  arf_out_b_sel,
    output logic [1:0]  arf_funsel,
    output logic [3:0]  arf_r_sel,
    output logic [15:0] ir,
    output logic        ir_valid,
    output logic        busy,
    output logic        fetch_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] OUT_B_PC  = 2'b11;
    localparam logic [1:0] FUN_INC   = 2'b01;
    localparam logic [3:0] RSEL_PC   = 4'b0001;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ_L = 3'd1,
        S_INC_L = 3'd2,
        S_REQ_H = 3'd3,
        S_INC_H = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [7:0]         lo_q, lo_d;
    logic [7:0]         hi_q, hi_d;
    logic [15:0]        ir_q, ir_d;
    logic               timeout_hit;

    // The not-ready cycle that would bring the counter up to TIMEOUT aborts.
    assign timeout_hit = (wait_cnt_q == CNT_W'(TIMEOUT - 1));

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            lo_q       <= 8'h00;
            hi_q       <= 8'h00;
            ir_q       <= 16'h0000;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            ir_q       <= ir_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_REQ_L;
                end
            end
            S_REQ_L: begin
                if (mem_rdy) begin
                    state_d = S_INC_L;
                end else if (timeout_hit) begin
                    state_d = S_ERR;
                end
            end
            S_INC_L: begin
                state_d = S_REQ_H;
            end
            S_REQ_H: begin
                if (mem_rdy) begin
                    state_d = S_INC_H;
                end else if (timeout_hit) begin
                    state_d = S_ERR;
                end
            end
            S_INC_H: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Wait counter, byte staging and IR load.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        ir_d       = ir_q;
        case (state_q)
            // Both exits into a request state clear the counter.
            S_IDLE, S_INC_L: begin
                wait_cnt_d = '0;
            end
            S_REQ_L: begin
                if (mem_rdy) begin
                    lo_d = mem_data;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            S_REQ_H: begin
                if (mem_rdy) begin
                    hi_d = mem_data;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            // Both bytes land in IR together on the edge that enters DONE.
            S_INC_H: begin
                ir_d = {hi_q, lo_q};
            end
            default: begin
                wait_cnt_d = wait_cnt_q;
            end
        endcase
    end

    // Moore outputs decoded from the state register.
    always_comb begin
        mem_rd        = 1'b0;
        mem_addr      = 8'h00;
        arf_out_b_sel = 2'b00;
        arf_funsel    = 2'b00;
        arf_r_sel     = 4'b0000;
        ir_valid      = 1'b0;
        fetch_err     = 1'b0;
        busy          = (state_q != S_IDLE);
        case (state_q)
            S_REQ_L, S_REQ_H: begin
                mem_rd        = 1'b1;
                arf_out_b_sel = OUT_B_PC;
                mem_addr      = pc_addr;
            end
            S_INC_L, S_INC_H: begin
                arf_r_sel  = RSEL_PC;
                arf_funsel = FUN_INC;
            end
            S_DONE: begin
                ir_valid = 1'b1;
            end
            S_ERR: begin
                fetch_err = 1'b1;
            end
            default: begin
                mem_rd = 1'b0;
            end
        endcase
    end

    assign ir = ir_q;

endmodule

// File: tb/tb_ir_fetch_seq.sv
// ----------------------------------------------------------------------------
// tb_ir_fetch_seq
// Self-checking bench for ir_fetch_seq. Contains a behavioural ARF (PC with
// increment) and a byte memory. Every fetch is predicted from its schedule:
// the low/high wait counts give the cycle of each phase, the IR value, the
// final PC and any timeout.
// ----------------------------------------------------------------------------
module tb_ir_fetch_seq;

    localparam int unsigned T = 4;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  pc_addr;
    logic [7:0]  mem_data;
    logic        mem_rdy;
    logic        mem_rd;
    logic [7:0]  mem_addr;
    logic [1:0]  arf_out_b_sel;
    logic [1:0]  arf_funsel;
    logic [3:0]  arf_r_sel;
    logic [15:0] ir;
    logic        ir_valid;
    logic        busy;
    logic        fetch_err;

    logic [7:0]  pc;
    logic [7:0]  mem [256];
    logic [15:0] ir_prev;
    int          checks;
    int          errors;

    ir_fetch_seq #(.TIMEOUT(T)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .pc_addr       (pc_addr),
        .mem_data      (mem_data),
        .mem_rdy       (mem_rdy),
        .mem_rd        (mem_rd),
        .mem_addr      (mem_addr),
        .arf_out_b_sel (arf_out_b_sel),
        .arf_funsel    (arf_funsel),
        .arf_r_sel     (arf_r_sel),
        .ir            (ir),
        .ir_valid      (ir_valid),
        .busy          (busy),
        .fetch_err     (fetch_err)
    );

    // ARF B port: PC when selected, an unrelated register otherwise.
    assign pc_addr = (arf_out_b_sel == 2'b11) ? pc : 8'h5A;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock: the ARF applies an increment requested in the ending cycle.
    task automatic tick();
        bit inc;
        inc = arf_r_sel[0] && (arf_funsel == 2'b01);
        @(posedge clk);
        if (inc) pc = pc + 8'd1;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            start    = 1'b0;
            mem_rdy  = 1'($urandom_range(0, 1));
            mem_data = 8'($urandom);
            check_eq("idle_busy", 32'(busy), 32'(0));
            check_eq("idle_rd", 32'(mem_rd), 32'(0));
            check_eq("idle_valid", 32'(ir_valid), 32'(0));
            check_eq("idle_err", 32'(fetch_err), 32'(0));
            check_eq("idle_ir", 32'(ir), 32'(ir_prev));
            tick();
        end
    endtask

    // One fetch from the current PC: wl/wh are the not-ready cycles the
    // memory inserts before answering the low/high read.
    task automatic run_fetch(input int wl, input int wh, input bit hold);
        logic [7:0]  pc0, pc1, exp_pc, exp_addr;
        logic [15:0] ir_new;
        bit          err_l, err_h;
        bit          in_rl, in_il, in_rh, in_ih, in_done, in_err;
        int          len_l, len_h, last;
        pc0    = pc;
        pc1    = pc0 + 8'd1;
        ir_new = {mem[pc1], mem[pc0]};
        err_l  = (wl >= int'(T));
        err_h  = !err_l && (wh >= int'(T));
        len_l  = err_l ? int'(T) : wl + 1;
        len_h  = err_h ? int'(T) : wh + 1;
        if (err_l)      last = len_l + 1;
        else if (err_h) last = len_l + len_h + 2;
        else            last = len_l + len_h + 3;
        for (int k = 0; k <= last; k++) begin
            in_rl   = (k >= 1) && (k <= len_l);
            in_il   = !err_l && (k == len_l + 1);
            in_rh   = !err_l && (k >= len_l + 2) && (k <= len_l + 1 + len_h);
            in_ih   = !err_l && !err_h && (k == len_l + len_h + 2);
            in_done = !err_l && !err_h && (k == last);
            in_err  = (err_l || err_h) && (k == last);
            start = (k == 0 || hold) ? 1'b1 : 1'($urandom_range(0, 1));
            if (in_rl)             mem_rdy = !err_l && (k == len_l);
            else if (in_rh)        mem_rdy = !err_h && (k == len_l + 1 + len_h);
            else if (in_il || in_ih) mem_rdy = 1'b1;
            else                   mem_rdy = 1'($urandom_range(0, 1));
            if (in_rl && mem_rdy)      mem_data = mem[pc0];
            else if (in_rh && mem_rdy) mem_data = mem[pc1];
            else                       mem_data = 8'($urandom);
            exp_addr = in_rl ? pc0 : (in_rh ? pc1 : 8'h00);
            check_eq("busy", 32'(busy), 32'(k != 0));
            check_eq("mem_rd", 32'(mem_rd), 32'(in_rl || in_rh));
            check_eq("mem_addr", 32'(mem_addr), 32'(exp_addr));
            check_eq("out_b_sel", 32'(arf_out_b_sel), (in_rl || in_rh) ? 32'(3) : 32'(0));
            check_eq("r_sel", 32'(arf_r_sel), (in_il || in_ih) ? 32'(1) : 32'(0));
            check_eq("funsel", 32'(arf_funsel), (in_il || in_ih) ? 32'(1) : 32'(0));
            check_eq("ir_valid", 32'(ir_valid), 32'(in_done));
            check_eq("fetch_err", 32'(fetch_err), 32'(in_err));
            check_eq("ir", 32'(ir), in_done ? 32'(ir_new) : 32'(ir_prev));
            tick();
        end
        exp_pc = err_l ? pc0 : (err_h ? pc1 : pc0 + 8'd2);
        check_eq("pc_after", 32'(pc), 32'(exp_pc));
        check_eq("busy_after", 32'(busy), 32'(0));
        if (!err_l && !err_h) ir_prev = ir_new;
    endtask

    // Reset asserted in REQ_H: outputs clear without a clock edge.
    task automatic reset_mid_fetch();
        logic [7:0] pc0;
        pc0 = pc;
        for (int k = 0; k < 3; k++) begin
            start    = (k == 0);
            mem_rdy  = 1'b1;
            mem_data = (k == 1) ? mem[pc0] : 8'($urandom);
            tick();
        end
        start   = 1'b0;
        mem_rdy = 1'b0;
        check_eq("rst_pre_rd", 32'(mem_rd), 32'(1));
        check_eq("rst_pre_addr", 32'(mem_addr), 32'(pc0 + 8'd1));
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_rd", 32'(mem_rd), 32'(0));
        check_eq("rst_addr", 32'(mem_addr), 32'(0));
        check_eq("rst_outb", 32'(arf_out_b_sel), 32'(0));
        check_eq("rst_fun", 32'(arf_funsel), 32'(0));
        check_eq("rst_rsel", 32'(arf_r_sel), 32'(0));
        check_eq("rst_valid", 32'(ir_valid), 32'(0));
        check_eq("rst_busy", 32'(busy), 32'(0));
        check_eq("rst_err", 32'(fetch_err), 32'(0));
        check_eq("rst_ir", 32'(ir), 32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ir_prev = 16'h0000;
        check_eq("rst_pc_kept", 32'(pc), 32'(pc0 + 8'd1));
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        ir_prev  = 16'h0000;
        pc       = 8'h00;
        rst_n    = 1'b0;
        start    = 1'b0;
        mem_rdy  = 1'b1;
        mem_data = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h10] = 8'hAB;
        mem[8'h11] = 8'hCD;

        #12;
        check_eq("reset_busy", 32'(busy), 32'(0));
        check_eq("reset_rd", 32'(mem_rd), 32'(0));
        check_eq("reset_addr", 32'(mem_addr), 32'(0));
        check_eq("reset_rsel", 32'(arf_r_sel), 32'(0));
        check_eq("reset_ir", 32'(ir), 32'(0));
        check_eq("reset_valid", 32'(ir_valid), 32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Basic fetch from 8'h10 with memory always ready.
        pc = 8'h10;
        run_fetch(0, 0, 1'b0);
        check_eq("basic_ir", 32'(ir), 32'(16'hCDAB));
        check_eq("basic_pc", 32'(pc), 32'(8'h12));
        idle(1);

        // Wait states: 3 in the low read, 2 in the high read.
        run_fetch(3, 2, 1'b0);
        idle(1);

        // Timeout in the low read leaves PC alone.
        pc = 8'h20;
        run_fetch(9, 0, 1'b0);
        check_eq("timeout_pc", 32'(pc), 32'(8'h20));
        idle(1);

        // Timeout in the high read leaves PC incremented once.
        run_fetch(1, 6, 1'b0);
        idle(1);

        // PC wrap between the two bytes.
        pc = 8'hFF;
        run_fetch(0, 1, 1'b0);
        check_eq("wrap_pc", 32'(pc), 32'(8'h01));
        idle(1);

        // Reset during REQ_H, then a normal fetch from the surviving PC.
        reset_mid_fetch();
        idle(1);
        run_fetch(0, 0, 1'b0);
        idle(1);

        // start held high: fetches run back to back.
        for (int i = 0; i < 3; i++) run_fetch(0, 0, 1'b1);
        idle(1);

        // Randomized fetches, including occasional timeouts.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) pc = 8'($urandom);
            run_fetch(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                      1'($urandom_range(0, 1)));
            idle(int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
